// File: rtl/render_pkg.sv
// Shared definitions for the render command path:
// opcodes, word field positions, decoder states and the decoded command bundle.
package render_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_DRAW      = 8'h01;
    localparam logic [7:0] OP_END_FRAME = 8'hFF;

    localparam int OP_HI  = 47;
    localparam int OP_LO  = 40;
    localparam int X_HI   = 39;
    localparam int X_LO   = 30;
    localparam int Y_HI   = 29;
    localparam int Y_LO   = 20;
    localparam int SPR_HI = 19;
    localparam int SPR_LO = 10;

    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DECODE,
        ISSUE,
        NEXT,
        DONE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] sprite;
    } render_cmd_t;

endpackage

// File: rtl/render_cmd_field_check.sv
// Combinational opcode and clip classification of one render command word.
// Exactly one of the four outputs is high for any input.
module render_cmd_field_check
    import render_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
)(
    input  logic [OP_HI:SPR_LO] i_word,
    output logic                o_is_end,
    output logic                o_is_nop,
    output logic                o_is_draw,
    output logic                o_drop
);

    logic [7:0]         w_op;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic [COORD_W-1:0] w_unused_spr;
    logic               w_in_view;

    assign w_op         = i_word[OP_HI:OP_LO];
    assign w_x          = i_word[X_HI:X_LO];
    assign w_y          = i_word[Y_HI:Y_LO];
    assign w_unused_spr = i_word[SPR_HI:SPR_LO];

    assign w_in_view = (int'(w_x) < H_ACTIVE) && (int'(w_y) < V_ACTIVE);

    assign o_is_end  = (w_op == OP_END_FRAME);
    assign o_is_nop  = (w_op == OP_NOP);
    assign o_is_draw = (w_op == OP_DRAW) && w_in_view;
    // Clipped draws and unknown opcodes both land here
    assign o_drop    = !(o_is_end || o_is_nop || o_is_draw);

endmodule

// File: rtl/render_cmd_decoder.sv
// Per-frame consumer of the render queue: pops, validates and hands
// decoded draw commands to the sprite engine over valid/ready.
module render_cmd_decoder
    import render_pkg::*;
#(
    parameter int CMD_W      = 48,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MAX_CMDS   = 25,
    parameter int DROP_CNT_W = 16
)(
    input  logic                  clk50,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  q_empty,
    input  logic [CMD_W-1:0]      q_dout,
    output logic                  q_pop_front,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [9:0]            cmd_x,
    output logic [9:0]            cmd_y,
    output logic [9:0]            cmd_sprite,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int CNT_W = $clog2(MAX_CMDS + 1);

    state_t             r_state;
    logic [OP_HI:SPR_LO] r_word;
    render_cmd_t        r_cmd;
    logic [CNT_W-1:0]   r_cnt;

    logic w_is_end;
    logic w_is_nop;
    logic w_is_draw;
    logic w_drop;
    logic w_at_max;
    logic w_unused_rsv;

    assign w_unused_rsv = ^q_dout[SPR_LO-1:0];
    assign w_at_max     = (r_cnt == CNT_W'(MAX_CMDS));

    // Pop in the FETCH cycle so the registered queue data lands in WAIT
    assign q_pop_front = (r_state == FETCH) && !q_empty && !reset;

    assign cmd_x      = r_cmd.x;
    assign cmd_y      = r_cmd.y;
    assign cmd_sprite = r_cmd.sprite;

    render_cmd_field_check #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_check (
        .i_word    (r_word),
        .o_is_end  (w_is_end),
        .o_is_nop  (w_is_nop),
        .o_is_draw (w_is_draw),
        .o_drop    (w_drop)
    );

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_cmd        <= '0;
            r_cnt        <= '0;
            cmd_valid    <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        frame_active <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (!q_empty) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_word  <= q_dout[OP_HI:SPR_LO];
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_state <= DECODE;
                end
                DECODE: begin
                    unique case (1'b1)
                        w_is_end: begin
                            r_state <= DONE;
                        end
                        w_is_draw: begin
                            r_cmd.x      <= r_word[X_HI:X_LO];
                            r_cmd.y      <= r_word[Y_HI:Y_LO];
                            r_cmd.sprite <= r_word[SPR_HI:SPR_LO];
                            cmd_valid    <= 1'b1;
                            r_state      <= ISSUE;
                        end
                        w_is_nop: begin
                            r_state <= NEXT;
                        end
                        default: begin
                            if (w_drop && (drop_cnt != '1)) begin
                                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                            end
                            r_state <= NEXT;
                        end
                    endcase
                end
                ISSUE: begin
                    // Limit check folded in here to keep four cycles per draw
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (w_at_max) begin
                            overflow <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                NEXT: begin
                    if (w_at_max) begin
                        overflow <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                DONE: begin
                    frame_done   <= 1'b1;
                    frame_active <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
